// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: reset PC, fetch FSM states, queue entry layout.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {inst, pc} pairs between fetch and decode.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // Guard against overflow/underflow even though the fetch FSM never asks for it.
    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_valid = (count != 2'd0);
    assign head       = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one memory read in flight and queues
// returned words for decode; redirects flush the queue and drop stale responses.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  tag, tag_next;
    logic         issue;
    logic         push;
    logic         pop;
    logic [1:0]   qcount;
    logic [1:0]   post_count;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    // A pop coinciding with a redirect is void: execute owns the flush.
    assign pop        = id_valid && id_ready && !redirect_valid;
    assign post_count = qcount + 2'd1 - {1'b0, pop};

    always_comb begin
        state_next = state;
        pc_next    = pc;
        tag_next   = tag;
        issue      = 1'b0;
        push       = 1'b0;
        if (redirect_valid) begin
            pc_next = word_align(redirect_pc);
            if (state != FS_IDLE && !imem_valid) begin
                state_next = FS_DROP;
            end else begin
                state_next = FS_IDLE;
            end
        end else begin
            case (state)
                FS_IDLE: issue = (qcount < DEPTH_C);
                FS_WAIT: begin
                    if (imem_valid) begin
                        push       = 1'b1;
                        issue      = (post_count < DEPTH_C);
                        state_next = FS_IDLE;
                    end
                end
                FS_DROP: begin
                    if (imem_valid) begin
                        state_next = FS_IDLE;
                    end
                end
                default: state_next = FS_IDLE;
            endcase
            if (issue) begin
                pc_next    = pc + 32'd4;
                tag_next   = pc;
                state_next = FS_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FS_IDLE;
            pc    <= RESET_PC;
            tag   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            tag   <= tag_next;
        end
    end

    assign imem_req  = issue && rst;
    assign imem_addr = imem_req ? pc : 32'd0;

    assign push_entry.inst = imem_rdata;
    assign push_entry.pc   = tag;

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (qcount),
        .head_valid (id_valid),
        .head       (head)
    );

    assign id_inst = head.inst;
    assign id_pc   = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small fixed-latency instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_chk = 0;
    int n_err = 0;

    // memory model state
    int          mem_lat = 1;
    bit          pending = 0;
    logic [31:0] pend_addr;
    int          pend_cnt;

    // per-cycle samples
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_idv;
    logic [31:0] s_pc;
    logic [31:0] s_inst;

    localparam logic [31:0] XORV = 32'hA5A5_0000;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at negedge, then advance memory after posedge.
    task automatic cycle();
        @(negedge clk);
        s_req  = imem_req;
        s_addr = imem_addr;
        s_idv  = id_valid;
        s_pc   = id_pc;
        s_inst = id_inst;
        if (imem_req) begin
            pending   = 1;
            pend_addr = imem_addr;
            pend_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_valid     = 1'b0;
        if (pending) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = pend_addr ^ XORV;
                pending    = 0;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b0;
        imem_valid = 1'b0;
        pending    = 0;
        cycle();
        check({tag, "_rst_req"},  {31'd0, s_req}, 32'd0);
        check({tag, "_rst_addr"}, s_addr, 32'd0);
        check({tag, "_rst_idv"},  {31'd0, s_idv}, 32'd0);
        check({tag, "_rst_pc"},   s_pc, 32'd0);
        check({tag, "_rst_inst"}, s_inst, 32'd0);
        cycle();
        pending    = 0;
        imem_valid = 1'b0;
        rst        = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        imem_valid     = 1'b0;
        imem_rdata     = 32'd0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // 1: streaming with 1-cycle memory
        mem_lat = 1; id_ready = 1'b1;
        do_reset("t1");
        cycle();
        check("t1_req_c0",  {31'd0, s_req}, 32'd1);
        check("t1_addr_c0", s_addr, 32'h0000_3000);
        check("t1_idv_c0",  {31'd0, s_idv}, 32'd0);
        cycle();
        check("t1_addr_c1", s_addr, 32'h0000_3004);
        cycle();
        check("t1_addr_c2", s_addr, 32'h0000_3008);
        check("t1_idv_c2",  {31'd0, s_idv}, 32'd1);
        check("t1_pc_c2",   s_pc, 32'h0000_3000);
        check("t1_inst_c2", s_inst, 32'hA5A5_3000);
        cycle();
        check("t1_addr_c3", s_addr, 32'h0000_300C);
        check("t1_pc_c3",   s_pc, 32'h0000_3004);
        check("t1_inst_c3", s_inst, 32'hA5A5_3004);

        // 2: backpressure fills both entries, then drains in order
        do_reset("t2");
        id_ready = 1'b0;
        cycle();
        cycle();
        check("t2_addr_c1", s_addr, 32'h0000_3004);
        for (int i = 2; i < 6; i++) begin
            cycle();
            check($sformatf("t2_req_full_c%0d", i), {31'd0, s_req}, 32'd0);
        end
        check("t2_pc_c5", s_pc, 32'h0000_3000);
        id_ready = 1'b1;
        cycle();
        check("t2_req_c6", {31'd0, s_req}, 32'd0);
        check("t2_pc_c6",  s_pc, 32'h0000_3000);
        cycle();
        check("t2_pc_c7",   s_pc, 32'h0000_3004);
        check("t2_addr_c7", s_addr, 32'h0000_3008);
        cycle();
        check("t2_idv_c8",  {31'd0, s_idv}, 32'd0);
        check("t2_addr_c8", s_addr, 32'h0000_300C);
        cycle();
        check("t2_pc_c9", s_pc, 32'h0000_3008);

        // 3: redirect while a 3-cycle read is in flight
        mem_lat = 3;
        do_reset("t3");
        cycle(); cycle(); cycle();
        cycle();
        check("t3_addr_c3", s_addr, 32'h0000_3004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0002;
        cycle();
        check("t3_req_c4", {31'd0, s_req}, 32'd0);
        cycle();
        check("t3_idv_c5", {31'd0, s_idv}, 32'd0);
        check("t3_req_c5", {31'd0, s_req}, 32'd0);
        cycle();
        check("t3_idv_c6", {31'd0, s_idv}, 32'd0);
        check("t3_req_c6", {31'd0, s_req}, 32'd0);
        cycle();
        check("t3_idv_c7",  {31'd0, s_idv}, 32'd0);
        check("t3_addr_c7", s_addr, 32'h0040_0000);
        cycle(); cycle(); cycle();
        check("t3_idv_c10", {31'd0, s_idv}, 32'd0);
        cycle();
        check("t3_pc_c11",   s_pc, 32'h0040_0000);
        check("t3_inst_c11", s_inst, 32'hA5E5_0000);

        // 4: redirect coincident with a response
        mem_lat = 1;
        do_reset("t4");
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_5000;
        cycle();
        check("t4_req_c1", {31'd0, s_req}, 32'd0);
        cycle();
        check("t4_addr_c2", s_addr, 32'h0000_5000);
        check("t4_idv_c2",  {31'd0, s_idv}, 32'd0);
        cycle();
        check("t4_idv_c3", {31'd0, s_idv}, 32'd0);
        cycle();
        check("t4_pc_c4",   s_pc, 32'h0000_5000);
        check("t4_inst_c4", s_inst, 32'hA5A5_5000);

        // 5: PC wraps past the top of the address space
        do_reset("t5");
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        cycle();
        cycle();
        check("t5_addr_c2", s_addr, 32'hFFFF_FFFC);
        cycle();
        check("t5_addr_c3", s_addr, 32'h0000_0000);
        check("t5_req_c3",  {31'd0, s_req}, 32'd1);
        cycle();
        check("t5_pc_c4",   s_pc, 32'hFFFF_FFFC);
        check("t5_inst_c4", s_inst, 32'h5A5A_FFFC);
        check("t5_addr_c4", s_addr, 32'h0000_0004);

        // 6: asynchronous reset with the queue occupied and a read in flight
        mem_lat = 3;
        do_reset("t6");
        id_ready = 1'b0;
        cycle(); cycle(); cycle(); cycle();
        cycle();
        check("t6_idv_pre", {31'd0, s_idv}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_idv", {31'd0, id_valid}, 32'd0);
        check("t6_async_req", {31'd0, imem_req}, 32'd0);
        check("t6_async_pc",  id_pc, 32'd0);
        pending    = 0;
        imem_valid = 1'b0;
        cycle();
        pending    = 0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        mem_lat    = 1;
        id_ready   = 1'b1;
        rst        = 1'b1;
        cycle();
        check("t6_addr_c0", s_addr, 32'h0000_3000);
        cycle();
        check("t6_idv_c1",  {31'd0, s_idv}, 32'd0);
        check("t6_addr_c1", s_addr, 32'h0000_3004);
        cycle();
        check("t6_pc_c2",   s_pc, 32'h0000_3000);
        check("t6_inst_c2", s_inst, 32'hA5A5_3000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
